// File: rtl/score_pkg.sv
// Shared types and default timing for the score input conditioner.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      FIRED
   } hold_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
   localparam int unsigned DEF_HOLD_CYCLES     = 16;
   localparam int unsigned DEF_REPEAT_DELAY    = 8;
   localparam int unsigned DEF_REPEAT_PERIOD   = 4;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and registered rising-edge strobe.
module button_debouncer
   import score_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // rise is raised on the same edge the level flips high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         rise <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= ~level;
            rise  <= ~level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/score_input_conditioner.sv
// Button front-end for the score counter. Define SCORE_AUTOREPEAT_EN to enable
// auto-repeat of held increment buttons.
module score_input_conditioner
   import score_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_inc1,
   input  logic btn_inc10,
   input  logic btn_reset,
   output logic inc1_pulse,
   output logic inc10_pulse,
   output logic reset_ready,
   output logic reset_arming
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

   if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("score_input_conditioner: cycle-count parameters must be >= 1");
   end

   // bit 0: inc1, bit 1: inc10, bit 2: reset
   logic [2:0] lvl;
   logic [2:0] rise;
   logic [1:0] ev;
   logic       pending;

   hold_state_t   state, state_nx;
   logic [HW-1:0] hold_cnt, hold_cnt_nx;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc1 (
      .clk(clk), .rst_n(rst_n), .btn(btn_inc1), .level(lvl[0]), .rise(rise[0])
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc10 (
      .clk(clk), .rst_n(rst_n), .btn(btn_inc10), .level(lvl[1]), .rise(rise[1])
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
      .clk(clk), .rst_n(rst_n), .btn(btn_reset), .level(lvl[2]), .rise(rise[2])
   );

`ifdef SCORE_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX + 1);

   logic [1:0][RW-1:0] rep_cnt;
   logic [1:0]         rep_first;
   logic [1:0]         rep_ev;

   // rep_cnt counts cycles since the debounced rise, then since the last repeat
   always_comb begin
      rep_ev = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         rep_ev[i] = lvl[i] && (rep_cnt[i] == (rep_first[i] ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt   <= '0;
         rep_first <= '1;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            if (!lvl[i]) begin
               rep_cnt[i]   <= '0;
               rep_first[i] <= 1'b1;
            end else if (rep_ev[i]) begin
               rep_cnt[i]   <= RW'(1);
               rep_first[i] <= 1'b0;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign ev = rise[1:0] | rep_ev;
`else
   assign ev = rise[1:0];
`endif

   // inc10 wins a collision; inc1 is deferred one cycle via pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc1_pulse  <= 1'b0;
         inc10_pulse <= 1'b0;
         pending     <= 1'b0;
      end else if (state != IDLE) begin
         inc1_pulse  <= 1'b0;
         inc10_pulse <= 1'b0;
         pending     <= 1'b0;
      end else begin
         inc10_pulse <= ev[1];
         inc1_pulse  <= !ev[1] && (ev[0] || pending);
         pending     <= ev[1] && (ev[0] || pending);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         hold_cnt <= hold_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      hold_cnt_nx = hold_cnt;
      reset_ready = 1'b0;
      case (state)
         IDLE: begin
            hold_cnt_nx = '0;
            if (rise[2]) state_nx = ARMING;
         end
         ARMING: begin
            if (!lvl[2]) begin
               state_nx = IDLE;
            end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
               state_nx    = FIRED;
               reset_ready = 1'b1;
            end else begin
               hold_cnt_nx = hold_cnt + 1'b1;
            end
         end
         FIRED: begin
            if (!lvl[2]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // the LED lights on the debounced press itself, before the FSM registers it
      reset_arming = (state != IDLE) || rise[2];
   end

endmodule

// File: tb/tb_score_input_conditioner.sv
// Directed bench for score_input_conditioner; expectations follow SCORE_AUTOREPEAT_EN.
module tb_score_input_conditioner;

`ifdef SCORE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   localparam int R_DELAY  = 8;
   localparam int R_PERIOD = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_inc1, btn_inc10, btn_reset;
   logic inc1_pulse, inc10_pulse, reset_ready, reset_arming;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;
   int t1, last1, t10, last10, trr, arm_lo, arm_hi;

   score_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(16),
      .REPEAT_DELAY(R_DELAY),
      .REPEAT_PERIOD(R_PERIOD)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_inc1(btn_inc1),
      .btn_inc10(btn_inc10),
      .btn_reset(btn_reset),
      .inc1_pulse(inc1_pulse),
      .inc10_pulse(inc10_pulse),
      .reset_ready(reset_ready),
      .reset_arming(reset_arming)
   );

   always #5 clk = ~clk;

   // first pulse at t0; with auto-repeat, t0+8, t0+12, ... up to last
   function automatic bit exp_pulse(int i, int t0, int last);
      if (t0 <= 0) return 1'b0;
      if (i == t0) return 1'b1;
      return AR && (i >= t0 + R_DELAY) && (((i - t0 - R_DELAY) % R_PERIOD) == 0) && (i <= last);
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_exp();
      cyc    = 0;
      t1     = 0;
      last1  = 0;
      t10    = 0;
      last10 = 0;
      trr    = 0;
      arm_lo = 1;
      arm_hi = 0;
   endtask

   task automatic watch(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
         chk("inc1_pulse", inc1_pulse, exp_pulse(cyc, t1, last1));
         chk("inc10_pulse", inc10_pulse, exp_pulse(cyc, t10, last10));
         chk("reset_ready", reset_ready, cyc == trr);
         chk("reset_arming", reset_arming, (cyc >= arm_lo) && (cyc <= arm_hi));
         chk("no_overlap", inc1_pulse & inc10_pulse, 1'b0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      btn_inc1  = 1'b0;
      btn_inc10 = 1'b0;
      btn_reset = 1'b0;
      clear_exp();
      watch(3);
      rst_n = 1'b1;
      watch(4);

      // 1: clean inc1 press, 10 cycles
      clear_exp();
      btn_inc1 = 1'b1; t1 = 7; last1 = 16;
      watch(10);
      btn_inc1 = 1'b0;
      watch(10);

      // 2: bouncing inc10 settles at cycle 12
      clear_exp();
      t10 = 19; last10 = 28;
      for (int k = 0; k < 3; k++) begin
         btn_inc10 = 1'b1; watch(2);
         btn_inc10 = 1'b0; watch(2);
      end
      btn_inc10 = 1'b1;
      watch(10);
      btn_inc10 = 1'b0;
      watch(10);

      // 3: simultaneous press
      clear_exp();
      btn_inc1 = 1'b1; btn_inc10 = 1'b1; t10 = 7; t1 = 8;
      watch(6);
      btn_inc1 = 1'b0; btn_inc10 = 1'b0;
      watch(10);

      // 4a: full hold with an inc1 press during the hold
      clear_exp();
      btn_reset = 1'b1; trr = 22; arm_lo = 6; arm_hi = 36;
      watch(10);
      btn_inc1 = 1'b1;
      watch(5);
      btn_inc1 = 1'b0;
      watch(15);
      btn_reset = 1'b0;
      watch(12);

      // 4b: early release
      clear_exp();
      btn_reset = 1'b1; arm_lo = 6; arm_hi = 16;
      watch(10);
      btn_reset = 1'b0;
      watch(12);

      // 5: reset mid-debounce with inc1 held
      clear_exp();
      btn_inc1 = 1'b1;
      watch(3);
      rst_n = 1'b0;
      watch(3);
      rst_n = 1'b1;
      clear_exp();
      t1 = 7; last1 = 16;
      watch(10);
      btn_inc1 = 1'b0;
      watch(10);

      // 6: long hold of inc1
      clear_exp();
      btn_inc1 = 1'b1; t1 = 7; last1 = 36;
      watch(30);
      btn_inc1 = 1'b0;
      watch(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
